// File: rtl/aes_pkg.sv
// Shared AES types and helpers for the inverse-cipher datapath.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Byte k of a state is state_t[k], i.e. bits [127-8k -: 8]; row = k%4, col = k/4.
package aes_pkg;

    localparam int AES_STATE_W = 128;

    typedef logic [7:0] byte_t;

    // Element 0 is the most significant byte, matching the column-major byte order.
    typedef logic [0:15][7:0] state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    // out[r][c] = in[r][(c-r) mod 4]
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[r + 4*c] = s[r + 4*((c - r + 4) % 4)];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/inv_shift_sub_unit_if.sv
// Handshake bundle between the upstream round stage, this unit and AddRoundKey/InvMixColumns.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// Ports: in_valid, in_ready, in_state[128], out_valid, out_ready, out_state[128].
// master = the testbench/neighbouring stages, slave = inv_shift_sub_unit.
interface inv_shift_sub_unit_if;
    import aes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_state;
    logic   out_valid;
    logic   out_ready;
    state_t out_state;

    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );

endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box lookup, one byte.
// Latency: 0 cycles (pure lookup).
// Backpressure: none.
// Ports: in_byte[8] -> out_byte[8].
module aes_inv_sbox
    import aes_pkg::*;
(
    input  byte_t in_byte,
    output byte_t out_byte
);

    // Index 0 sits in the most significant byte, so row n below holds entries 16n..16n+15.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = INV_SBOX[in_byte];

endmodule

// File: rtl/inv_shift_rows.sv
// AES InvShiftRows permutation, 128 -> 128 bits.
// Latency: 0 cycles (pure wiring).
// Backpressure: none.
// Ports: in_state[128] -> out_state[128].
module inv_shift_rows
    import aes_pkg::*;
(
    input  state_t in_state,
    output state_t out_state
);

    assign out_state = aes_pkg::inv_shift_rows(in_state);

endmodule

// File: rtl/inv_shift_sub_unit.sv
// Iterative InvShiftRows + InvSubBytes stage: shift on capture, then LANES S-box lookups per cycle.
// Latency: accept in cycle 0 -> out_valid in cycle N_STEPS+1 (N_STEPS = 16/LANES).
// Backpressure: result held stable in DONE until out_ready; no new state accepted meanwhile.
// Ports: clk, rst_n (async, active-low), bus (slave modport: in_valid/in_ready/in_state,
//        out_valid/out_ready/out_state), busy (high in RUN or DONE).
// Option INV_SHIFT_SUB_BACK2BACK_EN: in DONE, in_ready follows out_ready so a new block can be
// captured in the delivery cycle. This creates a combinational out_ready -> in_ready path.
module inv_shift_sub_unit
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inv_shift_sub_unit_if.slave   bus,
    output logic                  busy
);

    localparam int N_STEPS = 16 / LANES;
    localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_shift_sub_unit: LANES must be 1, 2, 4, 8 or 16");
    end

    fsm_t             state_q;
    logic [CNT_W-1:0] cnt_q;
    state_t           work_q;
    state_t           work_nxt;
    state_t           shifted;
    logic             out_valid_q;
    logic             busy_q;
    logic [3:0]       base;
    byte_t            sbox_out [LANES];

    inv_shift_rows u_inv_shift_rows (
        .in_state  (bus.in_state),
        .out_state (shifted)
    );

    // First byte handled this step; truncation is safe because cnt*LANES <= 16-LANES.
    always_comb begin
        base = 4'(int'(cnt_q) * LANES);
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        byte_t lane_in;
        assign lane_in = work_q[base + 4'(l)];
        aes_inv_sbox u_sbox (
            .in_byte  (lane_in),
            .out_byte (sbox_out[l])
        );
    end

    always_comb begin
        work_nxt = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_nxt[base + 4'(l)] = sbox_out[l];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_q  <= shifted;
                        cnt_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    work_q <= work_nxt;
                    if (cnt_q == CNT_W'(N_STEPS - 1)) begin
                        cnt_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    // work_q is untouched here, so out_state stays stable under backpressure.
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
`ifdef INV_SHIFT_SUB_BACK2BACK_EN
                        if (bus.in_valid) begin
                            work_q  <= shifted;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

`ifdef INV_SHIFT_SUB_BACK2BACK_EN
    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
`else
    assign bus.in_ready  = (state_q == IDLE);
`endif
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = work_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_inv_shift_sub_unit.sv
// Directed bench for inv_shift_sub_unit: LANES=4 and LANES=1 instances side by side.
// Latency: n/a.
// Backpressure: driven by the bench through out_ready.
module tb_inv_shift_sub_unit;
    import aes_pkg::*;

    localparam logic [127:0] C1_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] Z_OUT  = {16{8'h52}};
    localparam logic [127:0] OTHER  = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    logic rst_n;
    logic busy4, busy1;
    int   checks = 0;
    int   errors = 0;
    int   n;

    always #5 clk = ~clk;

    inv_shift_sub_unit_if if4 ();
    inv_shift_sub_unit_if if1 ();

    inv_shift_sub_unit #(.LANES(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4),
        .busy  (busy4)
    );

    inv_shift_sub_unit #(.LANES(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1),
        .busy  (busy1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send4(input logic [127:0] d);
        if4.in_valid = 1'b1;
        if4.in_state = d;
        chk("in_ready4_at_accept", 128'(if4.in_ready), 128'd1);
        tick();
        if4.in_valid = 1'b0;
    endtask

    task automatic wait_v4(output int cnt);
        cnt = 0;
        while (if4.out_valid !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_v1(output int cnt);
        cnt = 0;
        while (if1.out_valid !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        if4.in_valid = 1'b0; if4.in_state = '0; if4.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_state = '0; if1.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // Reset state
        chk("rst_out_valid4", 128'(if4.out_valid), 128'd0);
        chk("rst_busy4",      128'(busy4),         128'd0);
        chk("rst_out_state4", if4.out_state,       128'd0);
        chk("rst_in_ready4",  128'(if4.in_ready),  128'd1);
        chk("rst_out_valid1", 128'(if1.out_valid), 128'd0);
        chk("rst_busy1",      128'(busy1),         128'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.1 round 1, LANES=4, out_ready held high
        if4.out_ready = 1'b1;
        send4(C1_IN);
        chk("c1_busy_run",     128'(busy4),        128'd1);
        chk("c1_in_ready_run", 128'(if4.in_ready), 128'd0);
        wait_v4(n);
        chk("c1_latency4",     128'(n),            128'd4);
        chk("c1_out_state",    if4.out_state,      C1_OUT);
`ifdef INV_SHIFT_SUB_BACK2BACK_EN
        chk("c1_in_ready_done", 128'(if4.in_ready), 128'd1);
`else
        chk("c1_in_ready_done", 128'(if4.in_ready), 128'd0);
`endif
        tick();
        chk("c1_out_valid_after", 128'(if4.out_valid), 128'd0);
        chk("c1_busy_after",      128'(busy4),         128'd0);
        chk("c1_in_ready_after",  128'(if4.in_ready),  128'd1);

        // All-zero state, LANES=1
        if1.out_ready = 1'b1;
        if1.in_valid  = 1'b1;
        if1.in_state  = '0;
        chk("z1_in_ready", 128'(if1.in_ready), 128'd1);
        tick();
        if1.in_valid = 1'b0;
        wait_v1(n);
        chk("z1_latency1",  128'(n),       128'd16);
        chk("z1_out_state", if1.out_state, Z_OUT);
        tick();
        chk("z1_out_valid_after", 128'(if1.out_valid), 128'd0);

        // Backpressure: hold out_ready low for 10 cycles in DONE
        if4.out_ready = 1'b0;
        send4('0);
        wait_v4(n);
        chk("bp_latency4",  128'(n),       128'd4);
        chk("bp_out_state", if4.out_state, Z_OUT);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_out_valid", 128'(if4.out_valid), 128'd1);
            chk("bp_hold_out_state", if4.out_state,       Z_OUT);
            chk("bp_hold_in_ready",  128'(if4.in_ready),  128'd0);
        end
        if4.out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", 128'(if4.out_valid), 128'd0);
        tick();
        chk("bp_single_transfer",   128'(if4.out_valid), 128'd0);

        // in_valid pulsed with another state during RUN is ignored
        send4(C1_IN);
        tick();
        if4.in_valid = 1'b1;
        if4.in_state = OTHER;
        chk("ign_in_ready_run", 128'(if4.in_ready), 128'd0);
        tick();
        if4.in_valid = 1'b0;
        wait_v4(n);
        chk("ign_latency_rest", 128'(n),       128'd2);
        chk("ign_out_state",    if4.out_state, C1_OUT);
        tick();
        chk("ign_no_second_block", 128'(busy4), 128'd0);
        tick();
        chk("ign_still_idle",      128'(busy4), 128'd0);

        // Reset two cycles into RUN
        send4(C1_IN);
        tick(); tick();
        chk("rr_busy_before", 128'(busy4), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_out_valid", 128'(if4.out_valid), 128'd0);
        chk("rr_busy",      128'(busy4),         128'd0);
        chk("rr_out_state", if4.out_state,       128'd0);
        chk("rr_in_ready",  128'(if4.in_ready),  128'd1);
        tick();
        rst_n = 1'b1;
        tick();
        send4(C1_IN);
        wait_v4(n);
        chk("rr_latency4",  128'(n),       128'd4);
        chk("rr_out_state_fresh", if4.out_state, C1_OUT);
        tick();

        // Back-to-back: A = C.1, B = all-zero held on the input
        if4.out_ready = 1'b1;
        send4(C1_IN);
        if4.in_valid = 1'b1;
        if4.in_state = '0;
        wait_v4(n);
        chk("b2b_latency_a", 128'(n),       128'd4);
        chk("b2b_out_a",     if4.out_state, C1_OUT);
`ifdef INV_SHIFT_SUB_BACK2BACK_EN
        chk("b2b_in_ready_done", 128'(if4.in_ready), 128'd1);
        tick();
        chk("b2b_captured_busy",      128'(busy4),         128'd1);
        chk("b2b_captured_out_valid", 128'(if4.out_valid), 128'd0);
        chk("b2b_captured_in_ready",  128'(if4.in_ready),  128'd0);
        if4.in_valid = 1'b0;
`else
        chk("b2b_in_ready_done", 128'(if4.in_ready), 128'd0);
        tick();
        chk("b2b_bubble_in_ready",  128'(if4.in_ready),  128'd1);
        chk("b2b_bubble_busy",      128'(busy4),         128'd0);
        chk("b2b_bubble_out_valid", 128'(if4.out_valid), 128'd0);
        tick();
        chk("b2b_captured_busy",    128'(busy4),         128'd1);
        if4.in_valid = 1'b0;
`endif
        wait_v4(n);
        chk("b2b_latency_b", 128'(n),       128'd4);
        chk("b2b_out_b",     if4.out_state, Z_OUT);
        tick();
        chk("b2b_done_after", 128'(if4.out_valid), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
